stage_sequencer: RTL

// - Multi-cycle control FSM for the single-issue RV32I core. Sequences fetch -> decode -> exec/dmem -> writeback, one instruction at a time.
// - Drives stage enables, the dmem request handshake, and PC update/select. Halts on ECALL/EBREAK, illegal instruction or dmem timeout.
// - Sits in top beside the decode, exec and writeback stages. Owns no datapath registers.

---
 rtl/stage_sequencer_pkg.sv | 37 +++
 rtl/stage_timer.sv | 45 ++++
 rtl/stage_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/stage_sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stage_sequencer_pkg: opcodes, state/fault encodings for the stage sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
package stage_sequencer_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int TIMER_W = 8;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    F_NONE    = 2'b00,
    F_ILLEGAL = 2'b01,
    F_TIMEOUT = 2'b10
  } fault_t;

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stage_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stage_timer: clearable saturating wait counter; expired marks the
// MEM_TIMEOUT-th enabled cycle since the last clear.
// Rev 1.0
// ----------------------------------------------------------------------------
module stage_timer
  import stage_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(MEM_TIMEOUT);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIMIT)) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds completed cycles, so the current cycle is count_q + 1
  assign expired = enable && ((count_q + TIMER_W'(1)) == LIMIT);

endmodule
`default_nettype wire

// File: rtl/stage_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stage_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM
// Rev 1.0
// ----------------------------------------------------------------------------
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_valid,
  input  logic [6:0]       dec_opcode,
  input  logic             dec_illegal,
  input  logic             br_taken,
  output logic             decode_en,
  output logic             exec_en,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             wb_en,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] instret
);

  seq_state_t       state_q,    state_d;
  logic [6:0]       opcode_q,   opcode_d;
  logic             br_taken_q, br_taken_d;
  fault_t           fault_q,    fault_d;
  logic [CNT_W-1:0] instret_q,  instret_d;
  logic             timer_clr;
  logic             timer_exp;

  stage_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clr),
    .enable (state_q == MEM),
    .expired(timer_exp)
  );

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    br_taken_d = br_taken_q;
    fault_d    = fault_q;
    instret_d  = instret_q;
    timer_clr  = 1'b0;
    case (state_q)
      FETCH: begin
        if (imem_valid) state_d = DECODE;
      end
      DECODE: begin
        opcode_d = dec_opcode;
        if (dec_illegal) begin
          state_d = HALT;
          fault_d = F_ILLEGAL;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        br_taken_d = br_taken;
        if (opcode_q == OP_SYSTEM) begin
          state_d = HALT;
          fault_d = F_NONE;
        end else if (is_mem_op(opcode_q)) begin
          state_d   = MEM;
          timer_clr = 1'b1;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        // an ack arriving on the expiry cycle still completes the access
        if (dmem_ack) begin
          state_d = WB;
        end else if (timer_exp) begin
          state_d = HALT;
          fault_d = F_TIMEOUT;
        end
      end
      WB: begin
        instret_d = instret_q + CNT_W'(1);
        state_d   = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      opcode_q   <= '0;
      br_taken_q <= 1'b0;
      fault_q    <= F_NONE;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      br_taken_q <= br_taken_d;
      fault_q    <= fault_d;
      instret_q  <= instret_d;
    end
  end

  // rst masks every output so an interrupted WB cannot commit in that cycle
  always_comb begin
    imem_req  = 1'b0;
    decode_en = 1'b0;
    exec_en   = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    wb_en     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    halted    = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH:  imem_req  = 1'b1;
        DECODE: decode_en = 1'b1;
        EXEC:   exec_en   = 1'b1;
        MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (opcode_q == OP_STORE);
        end
        WB: begin
          pc_we  = 1'b1;
          wb_en  = (opcode_q != OP_STORE) && (opcode_q != OP_BRANCH);
          pc_sel = (opcode_q == OP_JAL) || (opcode_q == OP_JALR) ||
                   ((opcode_q == OP_BRANCH) && br_taken_q);
        end
        HALT:   halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign fault   = rst ? 2'b00 : fault_q;
  assign instret = rst ? '0 : instret_q;

endmodule
`default_nettype wire
